// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester bus (req/we/addr/wdata/be/lock -> gnt/rvalid/rdata) plus SRAM macro pins; master = requesters+macro, slave = arbiter
interface sram_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0] req, we, lock, gnt, rvalid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic [NUM_REQ*DATA_WIDTH/8-1:0] be;
  logic [DATA_WIDTH-1:0] rdata, sram_bwen_n, sram_wdata, sram_rdata;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic sram_cen_n, sram_wen_n;
  modport master (
    output req, we, addr, wdata, be, lock, sram_rdata,
    input gnt, rvalid, rdata, sram_cen_n, sram_wen_n, sram_bwen_n, sram_addr, sram_wdata
  );
  modport slave (
    input req, we, addr, wdata, be, lock, sram_rdata,
    output gnt, rvalid, rdata, sram_cen_n, sram_wen_n, sram_bwen_n, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin NUM_REQ-to-1 single-port SRAM arbiter with registered command stage and tagged 2-cycle read return; ports clk_i, rst_i (async, active high), bus (sram_arbiter_if.slave); optional burst lock via SRAM_ARB_LOCK_EN
module sram_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input logic clk_i,
  input logic rst_i,
  sram_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int BW = DATA_WIDTH / 8;
  logic [PW-1:0] rr_ptr, gidx, idx, own1, own2;
  logic [NUM_REQ-1:0] elig, gnt;
  logic [DATA_WIDTH-1:0] be_bits;
  logic [BW-1:0] be_sel;
  logic any, wr, v2;
`ifdef SRAM_ARB_LOCK_EN
  typedef enum logic {ARB, LOCKED} state_t;
  state_t state;
  logic [PW-1:0] owner;
  assign elig = (state == LOCKED) ? bus.req & (NUM_REQ'(1) << owner) : bus.req;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= ARB;
      owner <= '0;
    end else if (state == ARB) begin
      if (any && bus.lock[gidx]) begin
        state <= LOCKED;
        owner <= gidx;
      end
    end else if (!bus.req[owner] || (gnt[owner] && !bus.lock[owner]))
      state <= ARB;
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
  assign elig = bus.req;
`endif
  always_comb begin
    gnt = '0;
    gidx = '0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PW'((int'(rr_ptr) + i) % NUM_REQ);
      if (gnt == '0 && elig[idx]) begin
        gnt[idx] = 1'b1;
        gidx = idx;
      end
    end
  end
  assign any = |gnt;
  assign wr = any & bus.we[gidx];
  assign be_sel = bus.be[int'(gidx)*BW +: BW];
  always_comb begin
    be_bits = '0;
    for (int b = 0; b < DATA_WIDTH; b++) be_bits[b] = be_sel[b/8];
  end
  assign bus.gnt = rst_i ? '0 : gnt;
  assign bus.rvalid = NUM_REQ'(v2) << own2;
  assign bus.rdata = bus.sram_rdata;
  // stage 1 is the SRAM command register itself (valid = ~cen_n, is_read = wen_n, owner = own1);
  // stage 2 keeps only read-valid and owner, which is all the return path needs
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      rr_ptr <= '0;
      bus.sram_cen_n <= 1'b1;
      bus.sram_wen_n <= 1'b1;
      bus.sram_bwen_n <= '1;
      bus.sram_addr <= '0;
      bus.sram_wdata <= '0;
      own1 <= '0;
      own2 <= '0;
      v2 <= 1'b0;
    end else begin
      if (any) begin
        rr_ptr <= PW'((int'(gidx) + 1) % NUM_REQ);
        bus.sram_addr <= bus.addr[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
        bus.sram_wdata <= bus.wdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
      end
      bus.sram_cen_n <= ~any;
      bus.sram_wen_n <= ~wr;
      bus.sram_bwen_n <= wr ? ~be_bits : '1;
      own1 <= gidx;
      v2 <= ~bus.sram_cen_n & bus.sram_wen_n;
      own2 <= own1;
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed self-checking bench for sram_arbiter (2- and 3-requester instances, behavioural SRAM)
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [0:4095];
  logic [31:0] q;
  sram_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();
  sram_arbiter_if #(.NUM_REQ(3), .ADDR_WIDTH(12), .DATA_WIDTH(32)) bus3 ();
  sram_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(12), .DATA_WIDTH(32)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  sram_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(12), .DATA_WIDTH(32)) dut3 (.clk_i(clk), .rst_i(rst), .bus(bus3));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (!bus.sram_cen_n) begin
      if (!bus.sram_wen_n)
        mem[bus.sram_addr] <= (mem[bus.sram_addr] & bus.sram_bwen_n) | (bus.sram_wdata & ~bus.sram_bwen_n);
      else
        q <= mem[bus.sram_addr];
    end
  assign bus.sram_rdata = q;
  assign bus3.sram_rdata = '0;

  task automatic test_reset();
    bus.req = 2'b11;
    bus.we = 2'b11;
    bus3.req = 3'b111;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL rst_gnt: got %b want 00", bus.gnt); end
    checks++; if (bus3.gnt !== 3'b000) begin errors++; $display("FAIL rst_gnt3: got %b want 000", bus3.gnt); end
    checks++; if (bus.sram_cen_n !== 1'b1 || bus.sram_wen_n !== 1'b1) begin errors++; $display("FAIL rst_cen_wen: got %b%b want 11", bus.sram_cen_n, bus.sram_wen_n); end
    checks++; if (bus.sram_bwen_n !== 32'hFFFFFFFF) begin errors++; $display("FAIL rst_bwen: got %h want ffffffff", bus.sram_bwen_n); end
    checks++; if (bus.sram_addr !== 12'h000 || bus.sram_wdata !== 32'h0) begin errors++; $display("FAIL rst_addr_wdata: got %h %h want 000 00000000", bus.sram_addr, bus.sram_wdata); end
    checks++; if (bus.rvalid !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b want 00", bus.rvalid); end
    bus.req = 2'b00;
    bus.we = 2'b00;
    bus3.req = 3'b000;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checks++; if (bus.sram_cen_n !== 1'b1 || bus.gnt !== 2'b00 || bus.rvalid !== 2'b00) begin errors++; $display("FAIL idle: cen_n=%b gnt=%b rvalid=%b want 1 00 00", bus.sram_cen_n, bus.gnt, bus.rvalid); end
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    bus.req = 2'b01;
    bus.we = 2'b01;
    bus.addr = {12'h000, 12'h010};
    bus.wdata = {32'h0, 32'hDEADBEEF};
    bus.be = 8'h03;
    #1;
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b want 01", bus.gnt); end
    @(negedge clk);
    bus.req = 2'b00;
    #1;
    checks++; if (bus.sram_cen_n !== 1'b0 || bus.sram_wen_n !== 1'b0) begin errors++; $display("FAIL wr_cmd: cen_n/wen_n got %b%b want 00", bus.sram_cen_n, bus.sram_wen_n); end
    checks++; if (bus.sram_bwen_n !== 32'hFFFF0000) begin errors++; $display("FAIL wr_bwen: got %h want ffff0000", bus.sram_bwen_n); end
    checks++; if (bus.sram_addr !== 12'h010 || bus.sram_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_addr_data: got %h %h want 010 deadbeef", bus.sram_addr, bus.sram_wdata); end
    @(negedge clk);
    #1;
    checks++; if (bus.sram_cen_n !== 1'b1 || bus.rvalid !== 2'b00) begin errors++; $display("FAIL wr_after: cen_n=%b rvalid=%b want 1 00", bus.sram_cen_n, bus.rvalid); end
    @(negedge clk);
    bus.req = 2'b10;
    bus.we = 2'b00;
    bus.addr = {12'h010, 12'h000};
    #1;
    checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL rd_gnt: got %b want 10", bus.gnt); end
    @(negedge clk);
    bus.req = 2'b00;
    #1;
    checks++; if (bus.sram_cen_n !== 1'b0 || bus.sram_wen_n !== 1'b1 || bus.sram_bwen_n !== 32'hFFFFFFFF) begin errors++; $display("FAIL rd_cmd: cen_n=%b wen_n=%b bwen=%h want 0 1 ffffffff", bus.sram_cen_n, bus.sram_wen_n, bus.sram_bwen_n); end
    checks++; if (bus.sram_addr !== 12'h010 || bus.rvalid !== 2'b00) begin errors++; $display("FAIL rd_addr: addr=%h rvalid=%b want 010 00", bus.sram_addr, bus.rvalid); end
    @(negedge clk);
    #1;
    checks++; if (bus.rvalid !== 2'b10) begin errors++; $display("FAIL rd_rvalid: got %b want 10", bus.rvalid); end
    checks++; if (bus.rdata[15:0] !== 16'hBEEF) begin errors++; $display("FAIL rd_data: got %h want ????beef", bus.rdata); end
    @(negedge clk);
    #1;
    checks++; if (bus.rvalid !== 2'b00) begin errors++; $display("FAIL rd_once: got %b want 00", bus.rvalid); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.req = 2'b11;
    bus.we = 2'b11;
    bus.be = 8'hFF;
    bus.addr = {12'h021, 12'h020};
    bus.wdata = {32'hB1B10021, 32'hA0A00020};
    #1;
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL b2b_g0: got %b want 01", bus.gnt); end
    @(negedge clk);
    #1;
    checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL b2b_g1: got %b want 10", bus.gnt); end
    checks++; if (bus.sram_addr !== 12'h020 || bus.sram_wdata !== 32'hA0A00020 || bus.sram_wen_n !== 1'b0) begin errors++; $display("FAIL b2b_c0: got %h %h wen_n=%b want 020 a0a00020 0", bus.sram_addr, bus.sram_wdata, bus.sram_wen_n); end
    @(negedge clk);
    bus.req = 2'b01;
    bus.addr = {12'h021, 12'h022};
    bus.wdata = {32'hB1B10021, 32'hC2C20022};
    #1;
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL b2b_g2: got %b want 01", bus.gnt); end
    checks++; if (bus.sram_addr !== 12'h021 || bus.sram_wdata !== 32'hB1B10021) begin errors++; $display("FAIL b2b_c1: got %h %h want 021 b1b10021", bus.sram_addr, bus.sram_wdata); end
    @(negedge clk);
    bus.addr = {12'h021, 12'h023};
    bus.wdata = {32'hB1B10021, 32'hD3D30023};
    #1;
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL b2b_same: got %b want 01", bus.gnt); end
    checks++; if (bus.sram_addr !== 12'h022) begin errors++; $display("FAIL b2b_c2: got %h want 022", bus.sram_addr); end
    @(negedge clk);
    bus.req = 2'b10;
    bus.addr = {12'h024, 12'h000};
    bus.wdata = {32'hE4E40024, 32'h0};
    #1;
    checks++; if (bus.gnt !== 2'b10) begin errors++; $display("FAIL b2b_g4: got %b want 10", bus.gnt); end
    checks++; if (bus.sram_addr !== 12'h023 || bus.sram_wdata !== 32'hD3D30023) begin errors++; $display("FAIL b2b_c3: got %h %h want 023 d3d30023", bus.sram_addr, bus.sram_wdata); end
    @(negedge clk);
    bus.req = 2'b00;
    bus.we = 2'b00;
    #1;
    checks++; if (bus.sram_addr !== 12'h024 || bus.rvalid !== 2'b00 || bus.gnt !== 2'b00) begin errors++; $display("FAIL b2b_c4: addr=%h rvalid=%b gnt=%b want 024 00 00", bus.sram_addr, bus.rvalid, bus.gnt); end
  endtask

  task automatic test_rotation();
    logic [1:0] eg, er;
    logic [31:0] ed;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.req = (i < 6) ? 2'b11 : 2'b00;
      bus.we = 2'b00;
      bus.addr = {12'h021, 12'h020};
      #1;
      eg = (i >= 6) ? 2'b00 : (i % 2 == 1) ? 2'b10 : 2'b01;
      checks++; if (bus.gnt !== eg) begin errors++; $display("FAIL rot_gnt[%0d]: got %b want %b", i, bus.gnt, eg); end
      if (i >= 2) begin
        er = ((i - 2) % 2 == 1) ? 2'b10 : 2'b01;
        ed = ((i - 2) % 2 == 1) ? 32'hB1B10021 : 32'hA0A00020;
        checks++; if (bus.rvalid !== er) begin errors++; $display("FAIL rot_rvalid[%0d]: got %b want %b", i, bus.rvalid, er); end
        checks++; if (bus.rdata !== ed) begin errors++; $display("FAIL rot_rdata[%0d]: got %h want %h", i, bus.rdata, ed); end
      end
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    bus.req = 2'b01;
    bus.we = 2'b00;
    bus.addr = {12'h021, 12'h020};
    #1;
    checks++; if (bus.gnt !== 2'b01) begin errors++; $display("FAIL mid_gnt: got %b want 01", bus.gnt); end
    @(negedge clk);
    bus.req = 2'b00;
    rst = 1'b1;
    #1;
    checks++; if (bus.sram_cen_n !== 1'b1 || bus.sram_wen_n !== 1'b1 || bus.sram_bwen_n !== 32'hFFFFFFFF) begin errors++; $display("FAIL mid_sram: cen_n=%b wen_n=%b bwen=%h want 1 1 ffffffff", bus.sram_cen_n, bus.sram_wen_n, bus.sram_bwen_n); end
    checks++; if (bus.sram_addr !== 12'h000 || bus.sram_wdata !== 32'h0 || bus.rvalid !== 2'b00) begin errors++; $display("FAIL mid_clear: addr=%h wdata=%h rvalid=%b want 000 0 00", bus.sram_addr, bus.sram_wdata, bus.rvalid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.rvalid !== 2'b00) begin errors++; $display("FAIL mid_rvalid[%0d]: got %b want 00", i, bus.rvalid); end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    bus3.req = 3'b100;
    bus3.we = 3'b000;
    bus3.addr = {12'h300, 12'h200, 12'h100};
    #1;
    checks++; if (bus3.gnt !== 3'b100) begin errors++; $display("FAIL wrap_g2: got %b want 100", bus3.gnt); end
    @(negedge clk);
    bus3.req = 3'b110;
    #1;
    checks++; if (bus3.gnt !== 3'b010) begin errors++; $display("FAIL wrap_ptr0: got %b want 010", bus3.gnt); end
    checks++; if (bus3.sram_addr !== 12'h300) begin errors++; $display("FAIL wrap_addr2: got %h want 300", bus3.sram_addr); end
    @(negedge clk);
    bus3.req = 3'b011;
    #1;
    checks++; if (bus3.gnt !== 3'b001) begin errors++; $display("FAIL wrap_ptr2: got %b want 001", bus3.gnt); end
    checks++; if (bus3.sram_addr !== 12'h200) begin errors++; $display("FAIL wrap_addr1: got %h want 200", bus3.sram_addr); end
    @(negedge clk);
    bus3.req = 3'b000;
    #1;
    checks++; if (bus3.sram_addr !== 12'h100 || bus3.gnt !== 3'b000) begin errors++; $display("FAIL wrap_addr0: addr=%h gnt=%b want 100 000", bus3.sram_addr, bus3.gnt); end
  endtask

  task automatic test_lock();
    logic [1:0] eg;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.req = (i < 5) ? 2'b11 : 2'b00;
      bus.we = 2'b00;
      bus.lock = (i < 3) ? 2'b01 : 2'b00;
      bus.addr = {12'h021, 12'h020};
      #1;
`ifdef SRAM_ARB_LOCK_EN
      eg = (i >= 5) ? 2'b00 : (i < 4) ? 2'b01 : 2'b10;
`else
      eg = (i >= 5) ? 2'b00 : (i % 2 == 1) ? 2'b10 : 2'b01;
`endif
      checks++; if (bus.gnt !== eg) begin errors++; $display("FAIL lock_gnt[%0d]: got %b want %b", i, bus.gnt, eg); end
    end
    bus.lock = 2'b00;
  endtask

  initial begin
    bus.req = '0;
    bus.we = '0;
    bus.lock = '0;
    bus.addr = '0;
    bus.wdata = '0;
    bus.be = '0;
    bus3.req = '0;
    bus3.we = '0;
    bus3.lock = '0;
    bus3.addr = '0;
    bus3.wdata = '0;
    bus3.be = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_rotation();
    test_reset_midop();
    test_wrap();
    test_lock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
